aq_ifu_icache_tag_ctrl: RTL and testbench

Controller and arbiter in front of the IFU icache tag array: 256 sets, two ways, and a shared FIFO replacement bit per set. It shares the single-port array between three requesters: the invalidate-all sequencer, the refill tag write, and the fetch lookup read. It drives the array's cen/wen/idx/din ports directly. It also performs the one-cycle-later hit compare on the returned tag data.

---
 rtl/aq_ifu_icache_tag_ctrl.sv | 160 ++++++++++++++++
 tb/tb_aq_ifu_icache_tag_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_ifu_icache_tag_ctrl.sv
// IFU icache tag array controller: invalidate sweep, refill/lookup arbitration, hit compare.
// Optional: `define AQ_ICACHE_INV_ON_RESET_EN to sweep the array automatically after reset.
module aq_ifu_icache_tag_ctrl #(
  parameter int TAG_INDEX = 8,
  parameter int TAG_WIDTH = 28,
  parameter int SET_NUM   = 256
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  input  logic                   inv_req,
  output logic                   inv_busy,
  output logic                   inv_done,
  input  logic                   refill_req,
  input  logic                   refill_way,
  input  logic [TAG_INDEX-1:0]   refill_idx,
  input  logic [TAG_WIDTH-1:0]   refill_tag,
  output logic                   refill_gnt,
  input  logic                   lookup_req,
  input  logic [TAG_INDEX-1:0]   lookup_idx,
  input  logic [TAG_WIDTH-1:0]   lookup_tag,
  output logic                   lookup_gnt,
  output logic                   lookup_vld,
  output logic [1:0]             lookup_hit,
  output logic                   lookup_victim,
  output logic                   icache_tag_cen,
  output logic [2:0]             icache_tag_wen,
  output logic [TAG_INDEX:0]     icache_tag_idx,
  output logic [2*TAG_WIDTH+2:0] icache_tag_din,
  input  logic [2*TAG_WIDTH+2:0] icache_tag_dout
);

  localparam int WAY_W = TAG_WIDTH + 1;
  localparam logic [TAG_INDEX-1:0] LAST = TAG_INDEX'(SET_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef AQ_ICACHE_INV_ON_RESET_EN
  localparam state_e RST_STATE = INV;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_e RST_STATE = IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_e               state_q;
  state_e               state_d;
  logic [TAG_INDEX-1:0] cnt_q;
  logic [TAG_INDEX-1:0] cnt_d;
  logic                 inv_busy_q;
  logic                 inv_busy_d;
  logic                 inv_done_q;
  logic                 inv_done_d;
  logic                 lk_vld_q;
  logic                 lk_vld_d;
  logic [TAG_WIDTH-1:0] lk_tag_q;
  logic [TAG_WIDTH-1:0] lk_tag_d;

  logic idle_arb;
  logic inv_act;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (inv_req) begin
          state_d = INV;
          cnt_d   = '0;
        end
      end
      INV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inv_busy_d = (state_d != IDLE);
    inv_done_d = (state_d == DONE);
  end

  // Grants are masked during reset so the array sees no access.
  assign idle_arb   = (state_q == IDLE) & ~cpurst;
  assign inv_act    = (state_q == INV) & ~cpurst;
  assign refill_gnt = idle_arb & refill_req;
  assign lookup_gnt = idle_arb & lookup_req & ~refill_req;

  always_comb begin
    icache_tag_cen = 1'b0;
    icache_tag_wen = 3'b000;
    icache_tag_idx = '0;
    icache_tag_din = '0;
    unique case (1'b1)
      inv_act: begin
        icache_tag_cen = 1'b1;
        icache_tag_wen = 3'b111;
        icache_tag_idx = {1'b0, cnt_q};
      end
      refill_gnt: begin
        icache_tag_cen = 1'b1;
        icache_tag_wen = {1'b1, refill_way, ~refill_way};
        icache_tag_idx = {1'b0, refill_idx};
        icache_tag_din = {~refill_way,
                          1'b1, refill_tag,
                          1'b1, refill_tag};
      end
      lookup_gnt: begin
        icache_tag_cen = 1'b1;
        icache_tag_idx = {1'b0, lookup_idx};
      end
      default: ;
    endcase
  end

  always_comb begin
    lk_vld_d = lookup_gnt;
    lk_tag_d = lookup_gnt ? lookup_tag : lk_tag_q;
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      inv_busy_q <= RST_BUSY;
      inv_done_q <= 1'b0;
      lk_vld_q   <= 1'b0;
      lk_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_busy_q <= inv_busy_d;
      inv_done_q <= inv_done_d;
      lk_vld_q   <= lk_vld_d;
      lk_tag_q   <= lk_tag_d;
    end
  end

  assign inv_busy   = inv_busy_q;
  assign inv_done   = inv_done_q;
  assign lookup_vld = lk_vld_q;

  // Array read data lands the cycle after the grant; compare against the held tag.
  always_comb begin
    lookup_hit[1] = lk_vld_q
                  & icache_tag_dout[2*WAY_W-1]
                  & (icache_tag_dout[2*WAY_W-2:WAY_W] == lk_tag_q);
    lookup_hit[0] = lk_vld_q
                  & icache_tag_dout[WAY_W-1]
                  & (icache_tag_dout[TAG_WIDTH-1:0] == lk_tag_q);
    lookup_victim = lk_vld_q & icache_tag_dout[2*WAY_W];
  end

endmodule

// File: tb/tb_aq_ifu_icache_tag_ctrl.sv
// Bench for aq_ifu_icache_tag_ctrl: vector table, sweep/reset sequences,
// randomized refill/lookup traffic against a set/way reference model.
module tb_aq_ifu_icache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inv_req;
  logic        inv_busy;
  logic        inv_done;
  logic        refill_req;
  logic        refill_way;
  logic [7:0]  refill_idx;
  logic [27:0] refill_tag;
  logic        refill_gnt;
  logic        lookup_req;
  logic [7:0]  lookup_idx;
  logic [27:0] lookup_tag;
  logic        lookup_gnt;
  logic        lookup_vld;
  logic [1:0]  lookup_hit;
  logic        lookup_victim;
  logic        cen;
  logic [2:0]  wen;
  logic [8:0]  idx;
  logic [58:0] din;
  logic [58:0] dout = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aq_ifu_icache_tag_ctrl dut (
    .forever_cpuclk  (clk),
    .cpurst          (rst),
    .inv_req         (inv_req),
    .inv_busy        (inv_busy),
    .inv_done        (inv_done),
    .refill_req      (refill_req),
    .refill_way      (refill_way),
    .refill_idx      (refill_idx),
    .refill_tag      (refill_tag),
    .refill_gnt      (refill_gnt),
    .lookup_req      (lookup_req),
    .lookup_idx      (lookup_idx),
    .lookup_tag      (lookup_tag),
    .lookup_gnt      (lookup_gnt),
    .lookup_vld      (lookup_vld),
    .lookup_hit      (lookup_hit),
    .lookup_victim   (lookup_victim),
    .icache_tag_cen  (cen),
    .icache_tag_wen  (wen),
    .icache_tag_idx  (idx),
    .icache_tag_din  (din),
    .icache_tag_dout (dout)
  );

  // Single-port tag SRAM with per-field write enables.
  logic [58:0] sram [512];
  logic [58:0] sram_t;
  always @(posedge clk) begin
    if (cen) begin
      if (wen == 3'b000) begin
        dout <= sram[idx];
      end else begin
        sram_t = sram[idx];
        if (wen[0]) sram_t[28:0]  = din[28:0];
        if (wen[1]) sram_t[57:29] = din[57:29];
        if (wen[2]) sram_t[58]    = din[58];
        sram[idx] <= sram_t;
      end
    end
  end

  // Reference: per set, two {valid, tag} ways and a FIFO bit.
  bit          m_v   [256][2];
  logic [27:0] m_tag [256][2];
  bit          m_fifo[256];

  function automatic void model_inv();
    for (int s = 0; s < 256; s++) begin
      m_v[s][0] = 0;
      m_v[s][1] = 0;
      m_tag[s][0] = '0;
      m_tag[s][1] = '0;
      m_fifo[s] = 0;
    end
  endfunction

  function automatic void model_refill(input logic w, input logic [7:0] s,
                                       input logic [27:0] t);
    m_v[s][w] = 1;
    m_tag[s][w] = t;
    m_fifo[s] = ~w;
  endfunction

  function automatic logic [2:0] model_lookup(input logic [7:0] s,
                                              input logic [27:0] t);
    logic h1, h0;
    h1 = m_v[s][1] && (m_tag[s][1] == t);
    h0 = m_v[s][0] && (m_tag[s][0] == t);
    return {m_fifo[s], h1, h0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rr;
    logic        rw;
    logic [7:0]  ri;
    logic [27:0] rt;
    logic        lr;
    logic [7:0]  li;
    logic [27:0] lt;
    logic        e_rg;
    logic        e_lg;
    logic        e_vld;
    logic [1:0]  e_hit;
    logic        e_vic;
    logic [2:0]  e_wen;
    logic [7:0]  e_idx;
  } vec_t;

  function automatic vec_t mk(
    input logic rr, input logic rw, input logic [7:0] ri, input logic [27:0] rt,
    input logic lr, input logic [7:0] li, input logic [27:0] lt,
    input logic e_rg, input logic e_lg, input logic e_vld,
    input logic [1:0] e_hit, input logic e_vic,
    input logic [2:0] e_wen, input logic [7:0] e_idx);
    vec_t v;
    v.rr = rr; v.rw = rw; v.ri = ri; v.rt = rt;
    v.lr = lr; v.li = li; v.lt = lt;
    v.e_rg = e_rg; v.e_lg = e_lg; v.e_vld = e_vld;
    v.e_hit = e_hit; v.e_vic = e_vic; v.e_wen = e_wen; v.e_idx = e_idx;
    return v;
  endfunction

  // Called at a falling edge; drives one cycle and checks before the rising edge.
  task automatic apply(input string nm, input vec_t v);
    inv_req    = 1'b0;
    refill_req = v.rr;
    refill_way = v.rw;
    refill_idx = v.ri;
    refill_tag = v.rt;
    lookup_req = v.lr;
    lookup_idx = v.li;
    lookup_tag = v.lt;
    #4;
    chk({nm, ".gnt"}, {refill_gnt, lookup_gnt}, {v.e_rg, v.e_lg});
    chk({nm, ".res"}, {lookup_vld, lookup_hit, lookup_victim},
        {v.e_vld, v.e_hit, v.e_vic});
    chk({nm, ".cen"}, cen, v.e_rg | v.e_lg);
    if (v.e_rg | v.e_lg)
      chk({nm, ".wen_idx"}, {wen, idx}, {v.e_wen, 1'b0, v.e_idx});
    if (v.e_rg)
      chk({nm, ".din"}, din, {~v.rw, 1'b1, v.rt, 1'b1, v.rt});
    @(negedge clk);
  endtask

  // Called at a falling edge with the sweep at index 'start'.
  task automatic sweep_body(input string nm, input int start);
    for (int i = start; i < 256; i++) begin
      #4;
      chk({nm, ".inv"},
          {inv_busy, inv_done, refill_gnt, lookup_gnt, cen, wen, idx},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 8'(i)});
      chk({nm, ".din0"}, din, 64'd0);
      @(negedge clk);
    end
    refill_req = 1'b0;
    lookup_req = 1'b0;
    #4;
    chk({nm, ".done"}, {inv_busy, inv_done, cen, refill_gnt, lookup_gnt},
        5'b11000);
    @(negedge clk);
    #4;
    chk({nm, ".idle"}, {inv_busy, inv_done}, 2'b00);
    @(negedge clk);
    model_inv();
  endtask

  vec_t tbl[16];
  logic [7:0]  idx_pool [4] = '{8'h3C, 8'h3D, 8'h00, 8'hFF};
  logic [27:0] tag_pool [3] = '{28'h0ABCDEF, 28'h1234567, 28'h0000000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  v;
    logic  p_vld;
    logic [2:0] p_res;
    logic [2:0] r;
    int    gnt_at;
    int    done_at;
    int    n_done;
    int    n_cen;

    tbl[0]  = mk(1, 1, 8'h3C, 28'h0ABCDEF, 0, 8'h00, 28'h0,
                 1, 0, 0, 2'b00, 0, 3'b110, 8'h3C);
    tbl[1]  = mk(0, 0, 8'h00, 28'h0, 1, 8'h3C, 28'h0ABCDEF,
                 0, 1, 0, 2'b00, 0, 3'b000, 8'h3C);
    tbl[2]  = mk(0, 0, 8'h00, 28'h0, 1, 8'h3C, 28'h0000001,
                 0, 1, 1, 2'b10, 0, 3'b000, 8'h3C);
    tbl[3]  = mk(0, 0, 8'h00, 28'h0, 0, 8'h00, 28'h0,
                 0, 0, 1, 2'b00, 0, 3'b000, 8'h00);
    tbl[4]  = mk(1, 0, 8'h3C, 28'h1234567, 1, 8'h3C, 28'h0ABCDEF,
                 1, 0, 0, 2'b00, 0, 3'b101, 8'h3C);
    tbl[5]  = mk(0, 0, 8'h00, 28'h0, 1, 8'h3C, 28'h0ABCDEF,
                 0, 1, 0, 2'b00, 0, 3'b000, 8'h3C);
    tbl[6]  = mk(0, 0, 8'h00, 28'h0, 1, 8'h3C, 28'h1234567,
                 0, 1, 1, 2'b10, 1, 3'b000, 8'h3C);
    tbl[7]  = mk(0, 0, 8'h00, 28'h0, 0, 8'h00, 28'h0,
                 0, 0, 1, 2'b01, 1, 3'b000, 8'h00);
    tbl[8]  = mk(0, 0, 8'h00, 28'h0, 1, 8'h3D, 28'h0000000,
                 0, 1, 0, 2'b00, 0, 3'b000, 8'h3D);
    tbl[9]  = mk(1, 0, 8'hFF, 28'hFFFFFFF, 0, 8'h00, 28'h0,
                 1, 0, 1, 2'b00, 0, 3'b101, 8'hFF);
    tbl[10] = mk(0, 0, 8'h00, 28'h0, 1, 8'hFF, 28'hFFFFFFF,
                 0, 1, 0, 2'b00, 0, 3'b000, 8'hFF);
    tbl[11] = mk(1, 1, 8'hFF, 28'h0000000, 1, 8'hFF, 28'hFFFFFFF,
                 1, 0, 1, 2'b01, 1, 3'b110, 8'hFF);
    tbl[12] = mk(0, 0, 8'h00, 28'h0, 1, 8'hFF, 28'hFFFFFFF,
                 0, 1, 0, 2'b00, 0, 3'b000, 8'hFF);
    tbl[13] = mk(0, 0, 8'h00, 28'h0, 1, 8'hFF, 28'h0000000,
                 0, 1, 1, 2'b01, 0, 3'b000, 8'hFF);
    tbl[14] = mk(0, 0, 8'h00, 28'h0, 0, 8'h00, 28'h0,
                 0, 0, 1, 2'b10, 0, 3'b000, 8'h00);
    tbl[15] = mk(0, 0, 8'h00, 28'h0, 0, 8'h00, 28'h0,
                 0, 0, 0, 2'b00, 0, 3'b000, 8'h00);

    rst = 1'b1;
    inv_req = 1'b0;
    refill_req = 1'b1;
    refill_way = 1'b0;
    refill_idx = 8'h12;
    refill_tag = 28'h5;
    lookup_req = 1'b0;
    lookup_idx = '0;
    lookup_tag = '0;
    model_inv();

    #12;
`ifdef AQ_ICACHE_INV_ON_RESET_EN
    chk("reset.busy", inv_busy, 1'b1);
`else
    chk("reset.busy", inv_busy, 1'b0);
`endif
    chk("reset.outs",
        {inv_done, lookup_vld, lookup_hit, lookup_victim,
         refill_gnt, lookup_gnt, cen, wen, idx}, 64'd0);
    chk("reset.din", din, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    refill_req = 1'b0;

`ifdef AQ_ICACHE_INV_ON_RESET_EN
    lookup_req = 1'b1;
    lookup_idx = 8'h3C;
    lookup_tag = 28'h0;
    gnt_at = -1;
    done_at = -1;
    n_done = 0;
    for (int c = 0; c < 400; c++) begin
      #4;
      if (inv_done) begin
        n_done++;
        done_at = c;
      end
      if (lookup_gnt) begin
        gnt_at = c;
        break;
      end
      @(negedge clk);
    end
    if (gnt_at < 0) @(negedge clk);
    chk("boot.gnt_cycle", gnt_at, 257);
    chk("boot.done_cycle", done_at, 256);
    chk("boot.done_count", n_done, 1);
    @(negedge clk);
    lookup_req = 1'b0;
    #4;
    chk("boot.result", {lookup_vld, lookup_hit, lookup_victim}, 4'b1000);
    @(negedge clk);
    model_inv();
`else
    inv_req = 1'b1;
    #4;
    chk("sweep1.start", {inv_busy, refill_gnt, lookup_gnt}, 3'b000);
    @(negedge clk);
    inv_req = 1'b0;
    refill_req = 1'b1;
    lookup_req = 1'b1;
    sweep_body("sweep1", 0);
`endif

    for (int i = 0; i < 16; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Lookup granted in the cycle that also sees inv_req.
    inv_req = 1'b1;
    lookup_req = 1'b1;
    lookup_idx = 8'h3C;
    lookup_tag = 28'h0ABCDEF;
    #4;
    chk("sweep2.lk_gnt", {lookup_gnt, inv_busy, cen, wen}, {1'b1, 1'b0, 1'b1, 3'b000});
    @(negedge clk);
    inv_req = 1'b0;
    #4;
    chk("sweep2.lk_res", {lookup_vld, lookup_hit, lookup_victim}, 4'b1101);
    chk("sweep2.first",
        {inv_busy, lookup_gnt, cen, wen, idx}, {1'b1, 1'b0, 1'b1, 3'b111, 9'd0});
    @(negedge clk);
    sweep_body("sweep2", 1);

    // Refill granted in the cycle that also sees inv_req.
    inv_req = 1'b1;
    refill_req = 1'b1;
    refill_way = 1'b1;
    refill_idx = 8'h05;
    refill_tag = 28'h0000007;
    #4;
    chk("sweep3.rf_gnt", {refill_gnt, inv_busy, cen, wen, idx},
        {1'b1, 1'b0, 1'b1, 3'b110, 9'h005});
    @(negedge clk);
    inv_req = 1'b0;
    sweep_body("sweep3", 0);
    apply("post3.lk", mk(0, 0, 8'h0, 28'h0, 1, 8'h05, 28'h0000007,
                         0, 1, 0, 2'b00, 0, 3'b000, 8'h05));
    apply("post3.res", mk(0, 0, 8'h0, 28'h0, 0, 8'h00, 28'h0,
                          0, 0, 1, 2'b00, 0, 3'b000, 8'h00));

    p_vld = 1'b0;
    p_res = 3'b000;
    for (int n = 0; n < 500; n++) begin
      v.rr = ($urandom_range(0, 2) == 0);
      v.rw = 1'($urandom_range(0, 1));
      v.ri = idx_pool[$urandom_range(0, 3)];
      v.rt = tag_pool[$urandom_range(0, 2)];
      v.lr = 1'($urandom_range(0, 1));
      v.li = idx_pool[$urandom_range(0, 3)];
      v.lt = tag_pool[$urandom_range(0, 2)];
      v.e_rg  = v.rr;
      v.e_lg  = v.lr & ~v.rr;
      v.e_vld = p_vld;
      v.e_hit = p_res[1:0];
      v.e_vic = p_res[2];
      v.e_wen = v.rr ? {1'b1, v.rw, ~v.rw} : 3'b000;
      v.e_idx = v.rr ? v.ri : v.li;
      p_vld = v.e_lg;
      p_res = v.e_lg ? model_lookup(v.li, v.lt) : 3'b000;
      if (v.e_rg) model_refill(v.rw, v.ri, v.rt);
      apply("rand", v);
    end
    r = p_res;
    apply("rand.tail", mk(0, 0, 8'h0, 28'h0, 0, 8'h00, 28'h0,
                          0, 0, p_vld, r[1:0], r[2], 3'b000, 8'h00));

    // Reset in the middle of a sweep.
    inv_req = 1'b1;
    @(negedge clk);
    inv_req = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
    #2;
    chk("rstmid.at100", {cen, idx}, {1'b1, 9'd100});
    rst = 1'b1;
    #1;
`ifdef AQ_ICACHE_INV_ON_RESET_EN
    chk("rstmid.outs", {inv_done, lookup_vld, lookup_hit, lookup_victim,
                        cen, wen, idx}, 64'd0);
`else
    chk("rstmid.outs", {inv_busy, inv_done, lookup_vld, lookup_hit,
                        lookup_victim, cen, wen, idx}, 64'd0);
`endif
    chk("rstmid.din", din, 64'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef AQ_ICACHE_INV_ON_RESET_EN
    sweep_body("rstboot", 0);
`else
    n_done = 0;
    n_cen = 0;
    for (int c = 0; c < 300; c++) begin
      #4;
      if (inv_done) n_done++;
      if (cen | inv_busy) n_cen++;
      @(negedge clk);
    end
    chk("rstmid.no_done", n_done, 0);
    chk("rstmid.no_access", n_cen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
